// File: rtl/wb_stage_pkg.sv
// Shared MEM/WB bus layout and WB-stage FSM encoding, imported by the MEM, WB and ID stages.
package wb_stage_pkg;

  localparam int MEM_WB_BUS_W = 74;

  localparam int PC_MSB     = 73;
  localparam int PC_LSB     = 42;
  localparam int RESULT_MSB = 41;
  localparam int RESULT_LSB = 10;
  localparam int RD_MSB     = 9;
  localparam int RD_LSB     = 5;
  localparam int RF_WE_BIT  = 4;
  localparam int HALT_BIT   = 3;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB pipeline register, run/halt FSM and retired-instruction counter.
module wb_stage
  import wb_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mem_to_wb_reg_valid,
  input  logic [MEM_WB_BUS_W-1:0] mem_data,
  output logic                    mem_wb_reg_allow_in,
  output logic [4:0]              wb_rd,
  output logic [31:0]             wb_wdata,
  output logic                    wb_we,
  output logic [31:0]             wb_pc,
  output logic                    wb_valid,
  output logic                    halted,
  output logic [63:0]             instret
);

  wb_state_e   state;
  logic        valid_q;
  logic [31:0] pc_q;
  logic [31:0] result_q;
  logic [4:0]  rd_q;
  logic        rf_we_q;
  logic        halt_q;
  logic [63:0] instret_q;
  logic        unused_reserved;

  assign unused_reserved = ^mem_data[2:0];

  assign mem_wb_reg_allow_in = (state == RUN);

  // An instruction captured on the edge that enters HALTED must never retire.
  assign wb_valid = valid_q && (state == RUN);
  assign wb_we    = wb_valid && rf_we_q && (rd_q != 5'd0);
  assign wb_rd    = rd_q;
  assign wb_wdata = result_q;
  assign wb_pc    = pc_q;
  assign halted   = (state == HALTED);
  assign instret  = instret_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q  <= 1'b0;
      pc_q     <= '0;
      result_q <= '0;
      rd_q     <= '0;
      rf_we_q  <= 1'b0;
      halt_q   <= 1'b0;
    end else if (mem_wb_reg_allow_in) begin
      valid_q <= mem_to_wb_reg_valid;
      if (mem_to_wb_reg_valid) begin
        pc_q     <= mem_data[PC_MSB:PC_LSB];
        result_q <= mem_data[RESULT_MSB:RESULT_LSB];
        rd_q     <= mem_data[RD_MSB:RD_LSB];
        rf_we_q  <= mem_data[RF_WE_BIT];
        halt_q   <= mem_data[HALT_BIT];
      end
    end else begin
      valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:     if (wb_valid && halt_q) state <= HALTED;
        HALTED:  state <= HALTED;
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instret_q <= '0;
    end else if (wb_valid) begin
      instret_q <= instret_q + 64'd1;
    end
  end

endmodule
